wbumux_host: RTL



---
 rtl/wbumux_pkg.sv | 23 ++
 rtl/wbumux_fifo.sv | 59 +++++
 rtl/wbumux_host.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wbumux_pkg.sv
// Shared widths, link framing and channel select for the host-side link mux.
// Optional build macro: WBUMUX_CMD_PRIORITY_EN (strict command priority on TX).
package wbumux_pkg;

    localparam int unsigned CHAN_W       = 7;
    localparam int unsigned LINK_W       = 8;
    localparam int unsigned CMD_FLAG_BIT = 7;

    typedef enum logic {
        CH_CMD = 1'b0,
        CH_CON = 1'b1
    } chan_e;

    // Build a link byte from a channel byte and its command/console flag.
    function automatic logic [LINK_W-1:0] link_frame(input logic is_cmd,
                                                     input logic [CHAN_W-1:0] d);
        logic [LINK_W-1:0] b;
        b = LINK_W'(d);
        b[CMD_FLAG_BIT] = is_cmd;
        return b;
    endfunction

endpackage

// File: rtl/wbumux_fifo.sv
// Synchronous channel FIFO, depth 2^LGFIFO, registered full/empty flags.
// Pointers carry one extra wrap bit; full means only the wrap bits differ.
module wbumux_fifo
    import wbumux_pkg::*;
#(
    parameter int unsigned LGFIFO = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [CHAN_W-1:0] i_wr_data,
    input  logic              i_rd,
    output logic [CHAN_W-1:0] o_rd_data_c,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned DEPTH = 1 << LGFIFO;
    localparam int unsigned PTR_W = LGFIFO + 1;
    localparam logic [PTR_W-1:0] FULL_DIFF = PTR_W'(DEPTH);

    logic [CHAN_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt_c, rd_ptr_nxt_c;
    logic              wr_en_c, rd_en_c;

    // Accept decisions use the flags as they stand before this cycle's read.
    always_comb begin
        wr_en_c      = i_wr && !o_full;
        rd_en_c      = i_rd && !o_empty;
        wr_ptr_nxt_c = wr_ptr + PTR_W'(wr_en_c);
        rd_ptr_nxt_c = rd_ptr + PTR_W'(rd_en_c);
    end

    // Pointer and flag registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            wr_ptr  <= wr_ptr_nxt_c;
            rd_ptr  <= rd_ptr_nxt_c;
            o_full  <= (wr_ptr_nxt_c ^ rd_ptr_nxt_c) == FULL_DIFF;
            o_empty <= wr_ptr_nxt_c == rd_ptr_nxt_c;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem[wr_ptr[LGFIFO-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data_c = mem[rd_ptr[LGFIFO-1:0]];

endmodule

// File: rtl/wbumux_host.sv
// Host-side link mux: splits the UART stream into command/console channels
// and merges the two outgoing channels back onto the link.
// Optional build macro: WBUMUX_CMD_PRIORITY_EN (command channel always wins).
module wbumux_host
    import wbumux_pkg::*;
#(
    parameter int unsigned LGFIFO = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_stb,
    input  logic [LINK_W-1:0] i_rx_data,
    output logic              o_cmd_stb,
    output logic [CHAN_W-1:0] o_cmd_data,
    output logic              o_con_stb,
    output logic [CHAN_W-1:0] o_con_data,
    input  logic              i_cmd_stb,
    input  logic [CHAN_W-1:0] i_cmd_data,
    output logic              o_cmd_busy,
    input  logic              i_con_stb,
    input  logic [CHAN_W-1:0] i_con_data,
    output logic              o_con_busy,
    output logic              o_tx_stb,
    output logic [LINK_W-1:0] o_tx_data,
    input  logic              i_tx_busy
);

    logic              cmd_empty, con_empty;
    logic [CHAN_W-1:0] cmd_rd_c, con_rd_c;
    logic              load_ok_c, pop_cmd_c, pop_con_c;
`ifndef WBUMUX_CMD_PRIORITY_EN
    chan_e             rr, rr_nxt_c;
    logic              both_c;
`endif

    // RX demux: route each link byte to its channel one cycle later.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cmd_stb  <= 1'b0;
            o_cmd_data <= '0;
            o_con_stb  <= 1'b0;
            o_con_data <= '0;
        end else begin
            o_cmd_stb <= i_rx_stb && i_rx_data[CMD_FLAG_BIT];
            o_con_stb <= i_rx_stb && !i_rx_data[CMD_FLAG_BIT];
            if (i_rx_stb && i_rx_data[CMD_FLAG_BIT]) begin
                o_cmd_data <= i_rx_data[CHAN_W-1:0];
            end
            if (i_rx_stb && !i_rx_data[CMD_FLAG_BIT]) begin
                o_con_data <= i_rx_data[CHAN_W-1:0];
            end
        end
    end

    wbumux_fifo #(.LGFIFO(LGFIFO)) u_cmd_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr        (i_cmd_stb),
        .i_wr_data   (i_cmd_data),
        .i_rd        (pop_cmd_c),
        .o_rd_data_c (cmd_rd_c),
        .o_full      (o_cmd_busy),
        .o_empty     (cmd_empty)
    );

    wbumux_fifo #(.LGFIFO(LGFIFO)) u_con_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_wr        (i_con_stb),
        .i_wr_data   (i_con_data),
        .i_rd        (pop_con_c),
        .o_rd_data_c (con_rd_c),
        .o_full      (o_con_busy),
        .o_empty     (con_empty)
    );

    // Arbiter: pick which FIFO refills the output register this cycle.
    always_comb begin
        load_ok_c = !o_tx_stb || !i_tx_busy;
        pop_cmd_c = 1'b0;
        pop_con_c = 1'b0;
`ifdef WBUMUX_CMD_PRIORITY_EN
        if (load_ok_c) begin
            if (!cmd_empty)      pop_cmd_c = 1'b1;
            else if (!con_empty) pop_con_c = 1'b1;
        end
`else
        rr_nxt_c = rr;
        both_c   = !cmd_empty && !con_empty;
        if (load_ok_c) begin
            if (both_c) begin
                if (rr == CH_CMD) pop_cmd_c = 1'b1;
                else              pop_con_c = 1'b1;
                rr_nxt_c = (rr == CH_CMD) ? CH_CON : CH_CMD;
            end else if (!cmd_empty) begin
                pop_cmd_c = 1'b1;
            end else if (!con_empty) begin
                pop_con_c = 1'b1;
            end
        end
`endif
    end

`ifndef WBUMUX_CMD_PRIORITY_EN
    // Round-robin pointer register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) rr <= CH_CMD;
        else         rr <= rr_nxt_c;
    end
`endif

    // TX output register: holds while the UART is busy, reloads on transfer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_tx_stb  <= 1'b0;
            o_tx_data <= '0;
        end else if (load_ok_c) begin
            o_tx_stb <= pop_cmd_c || pop_con_c;
            if (pop_cmd_c)      o_tx_data <= link_frame(1'b1, cmd_rd_c);
            else if (pop_con_c) o_tx_data <= link_frame(1'b0, con_rd_c);
        end
    end

endmodule
